// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter: FSM state encoding
// and the smallest bit period the transmitter will honour.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } uart_state_e;

  localparam int unsigned MinDiv = 2;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with a registered head word: a write becomes visible at the
// head one cycle after it lands in storage.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             head_valid_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  mem_cnt_q;
  logic [CntW-1:0]  total;
  logic [WIDTH-1:0] head_q;
  logic             head_valid_q;
  logic             do_push, do_pop, do_load;

  // Occupancy counts the head register too, so full means DEPTH words in flight.
  assign total   = mem_cnt_q + CntW'(head_valid_q);
  assign full_o  = (total == CntW'(DEPTH));
  assign empty_o = (total == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && head_valid_q;
  assign do_load = (mem_cnt_q != '0) && (!head_valid_q || do_pop);

  assign head_o       = head_q;
  assign head_valid_o = head_valid_q;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      mem_cnt_q    <= '0;
      head_q       <= '0;
      head_valid_q <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (do_load) begin
        rd_ptr_q     <= rd_ptr_q + PtrW'(1);
        head_q       <= mem_q[rd_ptr_q];
        head_valid_q <= 1'b1;
      end else if (do_pop) begin
        head_valid_q <= 1'b0;
      end
      mem_cnt_q <= mem_cnt_q + CntW'(do_push) - CntW'(do_load);
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with transmit FIFO and runtime baud divisor.
// Define UART_TX_PARITY_EN to insert a parity bit between data and stop bits.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DIV_W-1:0]     div_i,
  input  logic                 par_odd_i,
  input  logic                 stb_i,
  input  logic [DATA_BITS-1:0] data_i,
  output logic                 rdy_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 tx_o
);

  localparam int unsigned BitW = $clog2(DATA_BITS);

  uart_state_e          state_q;
  logic [DIV_W-1:0]     div_q, cnt_q;
  logic [BitW-1:0]      bit_q;
  logic [DATA_BITS-1:0] sh_q;
  logic                 stop_q, tx_q, done_q;

  logic [DATA_BITS-1:0] head;
  logic                 head_valid, full, empty, pop;
  logic                 cnt_last, stop_last, last_data, frame_end;
  logic [DIV_W-1:0]     div_eff;

`ifdef UART_TX_PARITY_EN
  logic par_q;
`else
  logic unused_par_odd;
  assign unused_par_odd = par_odd_i;
`endif

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (stb_i),
    .data_i       (data_i),
    .pop_i        (pop),
    .head_o       (head),
    .head_valid_o (head_valid),
    .full_o       (full),
    .empty_o      (empty)
  );

  assign cnt_last  = (cnt_q == div_q - DIV_W'(1));
  assign stop_last = (stop_q == 1'(STOP_BITS - 1));
  assign last_data = (bit_q == BitW'(DATA_BITS - 1));
  assign frame_end = (state_q == StStop) && cnt_last && stop_last;
  // A queued word starts a frame from idle, or directly on the last stop edge.
  assign pop       = !rst_i && head_valid && ((state_q == StIdle) || frame_end);
  assign div_eff   = (div_i < DIV_W'(MinDiv)) ? DIV_W'(MinDiv) : div_i;

  always_ff @(posedge clk_i) begin
    done_q <= 1'b0;
    if (rst_i) begin
      state_q <= StIdle;
      div_q   <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      if (frame_end) begin
        done_q <= 1'b1;
      end
      if (pop) begin
        state_q <= StStart;
        sh_q    <= head;
        div_q   <= div_eff;
        cnt_q   <= '0;
        tx_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
        par_q   <= (^head) ^ par_odd_i;
`endif
      end else begin
        if (state_q != StIdle) begin
          cnt_q <= cnt_last ? '0 : cnt_q + DIV_W'(1);
        end
        unique case (state_q)
          StIdle: ;
          StStart: begin
            if (cnt_last) begin
              state_q <= StData;
              bit_q   <= '0;
              tx_q    <= sh_q[0];
              sh_q    <= sh_q >> 1;
            end
          end
          StData: begin
            if (cnt_last) begin
              if (last_data) begin
`ifdef UART_TX_PARITY_EN
                state_q <= StParity;
                tx_q    <= par_q;
`else
                state_q <= StStop;
                tx_q    <= 1'b1;
                stop_q  <= 1'b0;
`endif
              end else begin
                bit_q <= bit_q + BitW'(1);
                tx_q  <= sh_q[0];
                sh_q  <= sh_q >> 1;
              end
            end
          end
`ifdef UART_TX_PARITY_EN
          StParity: begin
            if (cnt_last) begin
              state_q <= StStop;
              tx_q    <= 1'b1;
              stop_q  <= 1'b0;
            end
          end
`endif
          StStop: begin
            if (cnt_last) begin
              if (stop_last) begin
                state_q <= StIdle;
              end else begin
                stop_q <= 1'b1;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign rdy_o  = !full && !rst_i;
  assign busy_o = (state_q != StIdle) || !empty;
  assign done_o = done_q;
  assign tx_o   = tx_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: directed and randomized frames compared
// against a frame-level timing model of the serial line.
module tb_uart_tx_cfg;

  localparam int unsigned DB = 8;
  localparam int unsigned SB = 1;
  localparam int unsigned FD = 4;
  localparam int unsigned DW = 16;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [DW-1:0] div_i = 16'd4;
  logic          par_odd_i = 1'b0;
  logic          stb_i = 1'b0;
  logic [DB-1:0] data_i = '0;
  logic          rdy_o, busy_o, done_o, tx_o;

  uart_tx_cfg #(
    .DATA_BITS  (DB),
    .STOP_BITS  (SB),
    .FIFO_DEPTH (FD),
    .DIV_W      (DW)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .div_i     (div_i),
    .par_odd_i (par_odd_i),
    .stb_i     (stb_i),
    .data_i    (data_i),
    .rdy_o     (rdy_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .tx_o      (tx_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Stimulus plan (strobes driven) and the words the spec says get accepted.
  int            push_e[$];
  logic [DB-1:0] push_w[$];
  int            acc_e[$];
  logic [DB-1:0] acc_w[$];
  int            div_old, div_new, div_chg;

  logic cap_tx[$], cap_done[$], cap_busy[$], cap_rdy[$];
  logic exp_tx[$], exp_done[$];

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic int frame_bits();
`ifdef UART_TX_PARITY_EN
    return 1 + DB + 1 + SB;
`else
    return 1 + DB + SB;
`endif
  endfunction

  function automatic int div_at(int i);
    int d;
    d = (i >= div_chg) ? div_new : div_old;
    return (d < 2) ? 2 : d;
  endfunction

  // Frames start two edges after acceptance, or on the previous frame's end edge.
  function automatic void build_expect(int n, logic par);
    int   t_free, s, d, e;
    logic fb[$];
    t_free = 0;
    exp_tx.delete();
    exp_done.delete();
    for (int i = 0; i < n; i++) begin
      exp_tx.push_back(1'b1);
      exp_done.push_back(1'b0);
    end
    for (int k = 0; k < acc_e.size(); k++) begin
      fb.delete();
      s = acc_e[k] + 2;
      if (t_free > s) s = t_free;
      d = div_at(s);
      fb.push_back(1'b0);
      for (int b = 0; b < DB; b++) fb.push_back(acc_w[k][b]);
`ifdef UART_TX_PARITY_EN
      fb.push_back((^acc_w[k]) ^ par);
`endif
      for (int b = 0; b < SB; b++) fb.push_back(1'b1);
      for (int b = 0; b < fb.size(); b++)
        for (int c = 0; c < d; c++)
          if (s + b * d + c < n) exp_tx[s + b * d + c] = fb[b];
      e = s + fb.size() * d;
      if (e < n) exp_done[e] = 1'b1;
      t_free = e;
    end
  endfunction

  function automatic int wave_diff();
    for (int i = 0; i < exp_tx.size(); i++)
      if (cap_tx[i] !== exp_tx[i] || cap_done[i] !== exp_done[i]) return i;
    return -1;
  endfunction

  function automatic int nth_done(int k);
    int seen = 0;
    for (int i = 0; i < cap_done.size(); i++)
      if (cap_done[i] === 1'b1) begin
        if (seen == k) return i;
        seen++;
      end
    return -1;
  endfunction

  function automatic int count_done();
    int c = 0;
    foreach (cap_done[i]) if (cap_done[i] === 1'b1) c++;
    return c;
  endfunction

  task automatic clear_plan();
    push_e.delete(); push_w.delete(); acc_e.delete(); acc_w.delete();
    div_chg = 1 << 30;
  endtask

  task automatic plan_push(input int e, input logic [DB-1:0] w, input bit accepted);
    push_e.push_back(e);
    push_w.push_back(w);
    if (accepted) begin
      acc_e.push_back(e);
      acc_w.push_back(w);
    end
  endtask

  task automatic run_seq(input int n, input int rst_at, input logic par);
    int k = 0;
    cap_tx.delete(); cap_done.delete(); cap_busy.delete(); cap_rdy.delete();
    par_odd_i = par;
    for (int i = 0; i < n; i++) begin
      div_i = DW'((i >= div_chg) ? div_new : div_old);
      rst_i = (i == rst_at);
      if (k < push_e.size() && push_e[k] == i) begin
        stb_i  = 1'b1;
        data_i = push_w[k];
        k++;
      end else begin
        stb_i = 1'b0;
      end
      step();
      cap_tx.push_back(tx_o);
      cap_done.push_back(done_o);
      cap_busy.push_back(busy_o);
      cap_rdy.push_back(rdy_o);
    end
    stb_i = 1'b0;
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    stb_i = 1'b0;
    step();
    step();
    checks++;
    if (tx_o !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx_o); end
    checks++;
    if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_o); end
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    checks++;
    if (rdy_o !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b want 0", rdy_o); end
    rst_i = 1'b0;
    step();
    checks++;
    if (rdy_o !== 1'b1) begin errors++; $display("FAIL post_reset_rdy: got %b want 1", rdy_o); end
    checks++;
    if (tx_o !== 1'b1) begin errors++; $display("FAIL post_reset_tx: got %b want 1", tx_o); end
  endtask

  task automatic test_single();
    int n, d, len;
    len = 4 * frame_bits();
    for (int p = 0; p < 2; p++) begin
      clear_plan();
      div_old = 4;
      plan_push(0, 8'hA5, 1'b1);
      n = len + 20;
      build_expect(n, p[0]);
      run_seq(n, -1, p[0]);
      checks++;
      d = wave_diff();
      if (d !== -1) begin
        errors++;
        $display("FAIL single_wave par=%0d: idx %0d tx=%b/%b done=%b/%b", p, d, cap_tx[d],
                 exp_tx[d], cap_done[d], exp_done[d]);
      end
      checks++;
      if (cap_tx[1] !== 1'b1 || cap_tx[2] !== 1'b0) begin
        errors++;
        $display("FAIL single_latency: got %b%b want 10", cap_tx[1], cap_tx[2]);
      end
      checks++;
      if (nth_done(0) !== 2 + len || count_done() !== 1) begin
        errors++;
        $display("FAIL single_done: got idx %0d cnt %0d want idx %0d cnt 1", nth_done(0),
                 count_done(), 2 + len);
      end
      checks++;
      // 0xA5 has four ones: even parity 0, odd parity 1; without parity the stop bit follows.
`ifdef UART_TX_PARITY_EN
      if (cap_tx[2 + 36] !== p[0]) begin
        errors++;
        $display("FAIL single_parity: got %b want %b", cap_tx[2 + 36], p[0]);
      end
`else
      if (cap_tx[2 + 36] !== 1'b1) begin
        errors++;
        $display("FAIL single_stop: got %b want 1", cap_tx[2 + 36]);
      end
`endif
      checks++;
      if (cap_busy[0] !== 1'b1 || cap_busy[2 + len] !== 1'b0) begin
        errors++;
        $display("FAIL single_busy: got %b%b want 10", cap_busy[0], cap_busy[2 + len]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n, d, len;
    len = 4 * frame_bits();
    clear_plan();
    div_old = 4;
    plan_push(0, 8'h00, 1'b1);
    plan_push(1, 8'hFF, 1'b1);
    plan_push(2, 8'h55, 1'b1);
    n = 3 * len + 20;
    build_expect(n, 1'b0);
    run_seq(n, -1, 1'b0);
    checks++;
    d = wave_diff();
    if (d !== -1) begin
      errors++;
      $display("FAIL b2b_wave: idx %0d tx=%b/%b done=%b/%b", d, cap_tx[d], exp_tx[d],
               cap_done[d], exp_done[d]);
    end
    checks++;
    if (nth_done(1) - nth_done(0) !== len || nth_done(2) - nth_done(1) !== len
        || count_done() !== 3) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d,%0d,%0d want spacing %0d", nth_done(0),
               nth_done(1), nth_done(2), len);
    end
  endtask

  task automatic test_fifo_full();
    int n, d;
    clear_plan();
    div_old = 100;
    for (int i = 0; i < 5; i++) plan_push(i, DB'($urandom), 1'b1);
    for (int i = 5; i < 1003; i++) plan_push(i, 8'h3C, 1'b0);
    plan_push(1003, 8'h3C, 1'b1);
    n = 2 + 6 * 100 * frame_bits() + 10;
    build_expect(n, 1'b1);
    run_seq(n, -1, 1'b1);
    checks++;
    d = wave_diff();
    if (d !== -1) begin
      errors++;
      $display("FAIL full_wave: idx %0d tx=%b/%b done=%b/%b", d, cap_tx[d], exp_tx[d],
               cap_done[d], exp_done[d]);
    end
    checks++;
    if (cap_rdy[3] !== 1'b1 || cap_rdy[4] !== 1'b0) begin
      errors++;
      $display("FAIL full_rdy_fill: got %b%b want 10", cap_rdy[3], cap_rdy[4]);
    end
    checks++;
    if (cap_rdy[1001] !== 1'b0 || cap_rdy[1002] !== 1'b1 || cap_rdy[1003] !== 1'b0) begin
      errors++;
      $display("FAIL full_rdy_pop: got %b%b%b want 010", cap_rdy[1001], cap_rdy[1002],
               cap_rdy[1003]);
    end
  endtask

  task automatic test_reset_mid();
    int n, d, r;
    clear_plan();
    div_old = 4;
    for (int i = 0; i < 3; i++) plan_push(i, DB'($urandom), 1'b1);
    r = 2 + 4 * 3;
    n = r + 200;
    build_expect(n, 1'b0);
    for (int i = r; i < n; i++) begin
      exp_tx[i]   = 1'b1;
      exp_done[i] = 1'b0;
    end
    run_seq(n, r, 1'b0);
    checks++;
    d = wave_diff();
    if (d !== -1) begin
      errors++;
      $display("FAIL rstmid_wave: idx %0d tx=%b/%b done=%b/%b", d, cap_tx[d], exp_tx[d],
               cap_done[d], exp_done[d]);
    end
    checks++;
    if (cap_busy[r - 1] !== 1'b1 || cap_busy[r] !== 1'b0 || cap_tx[r] !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_state: busy %b%b tx %b want busy 10 tx 1", cap_busy[r - 1],
               cap_busy[r], cap_tx[r]);
    end
    checks++;
    if (count_done() !== 0) begin
      errors++;
      $display("FAIL rstmid_done: got %0d pulses want 0", count_done());
    end
  endtask

  task automatic test_divisor();
    int n, d, fb;
    fb = frame_bits();
    clear_plan();
    div_old = 1;
    plan_push(0, 8'h6B, 1'b1);
    n = 2 * fb + 20;
    build_expect(n, 1'b1);
    run_seq(n, -1, 1'b1);
    checks++;
    d = wave_diff();
    if (d !== -1) begin
      errors++;
      $display("FAIL div_min_wave: idx %0d tx=%b/%b", d, cap_tx[d], exp_tx[d]);
    end
    checks++;
    if (nth_done(0) !== 2 + 2 * fb) begin
      errors++;
      $display("FAIL div_min_done: got %0d want %0d", nth_done(0), 2 + 2 * fb);
    end
    clear_plan();
    div_old = 4;
    div_new = 7;
    div_chg = 10;
    plan_push(0, 8'hC3, 1'b1);
    plan_push(1, 8'h1E, 1'b1);
    n = 11 * fb + 20;
    build_expect(n, 1'b0);
    run_seq(n, -1, 1'b0);
    checks++;
    d = wave_diff();
    if (d !== -1) begin
      errors++;
      $display("FAIL div_chg_wave: idx %0d tx=%b/%b", d, cap_tx[d], exp_tx[d]);
    end
    checks++;
    if (nth_done(0) !== 2 + 4 * fb || nth_done(1) !== 2 + 11 * fb) begin
      errors++;
      $display("FAIL div_chg_done: got %0d,%0d want %0d,%0d", nth_done(0), nth_done(1),
               2 + 4 * fb, 2 + 11 * fb);
    end
  endtask

  task automatic test_random();
    int n, d, nw, t, dmax;
    logic par;
    for (int r = 0; r < 8; r++) begin
      clear_plan();
      div_old = $urandom_range(0, 6);
      div_new = $urandom_range(0, 6);
      par     = 1'($urandom);
      nw      = $urandom_range(1, 4);
      t       = 0;
      for (int k = 0; k < nw; k++) begin
        plan_push(t, DB'($urandom), 1'b1);
        t += $urandom_range(1, 3);
      end
      dmax = 6;
      n = t + 3 + nw * dmax * frame_bits() + 10;
      if ($urandom_range(0, 1) == 1) div_chg = $urandom_range(0, n - 1);
      build_expect(n, par);
      run_seq(n, -1, par);
      checks++;
      d = wave_diff();
      if (d !== -1) begin
        errors++;
        $display("FAIL random_wave run %0d: idx %0d tx=%b/%b done=%b/%b", r, d, cap_tx[d],
                 exp_tx[d], cap_done[d], exp_done[d]);
      end
    end
  endtask

  initial begin
    div_chg = 1 << 30;
    div_old = 4;
    div_new = 4;
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_reset_mid();
    test_divisor();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
